// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store encodings, FSM states and request-decode helpers
// for the data memory unit.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
    function automatic logic func3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 <= F3_W);
        return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a RAM word and sign- or zero-extends it.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];

        data = 32'h0;
        case (func3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'h0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'h0, half_lane};
            F3_W:    data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store unit between the core and a variable-latency word RAM; stalls the core until done.
// Optional MISALIGN_TRAP_EN: misaligned accesses report err instead of being force-aligned.
module data_mem_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic        write_reg;
    logic [2:0]  func3_reg;
    logic [1:0]  lo_reg;
    logic [7:0]  timer_reg;

    logic        legal;
    logic        misaligned;
    logic [1:0]  lo_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    always_comb begin
        legal      = func3_legal(req_write, req_func3);
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned = is_misaligned(req_func3, req_addr[1:0]);
`endif
        // func3[1:0] is the access width for both signed and unsigned codes.
        case (req_func3[1:0])
            2'd0: begin
                lo_next = req_addr[1:0];
                be_next = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                lo_next = {req_addr[1], 1'b0};
                be_next = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                lo_next = 2'b00;
                be_next = 4'b1111;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_next[gi*8 +: 8] =
            (req_func3[1:0] == 2'd0) ? req_wdata[7:0] :
            (req_func3[1:0] == 2'd1) ? req_wdata[(gi%2)*8 +: 8] :
                                       req_wdata[gi*8 +: 8];
    end

    load_extend u_load_extend (
        .word    (mem_rdata),
        .addr_lo (lo_reg),
        .func3   (func3_reg),
        .data    (load_data)
    );

    assign stall = ((state_reg == ST_IDLE) && req_valid) || (state_reg == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            write_reg <= 1'b0;
            func3_reg <= 3'd0;
            lo_reg    <= 2'd0;
            timer_reg <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        func3_reg <= req_func3;
                        lo_reg    <= lo_next;
                        timer_reg <= 8'd0;
                        if (!legal || misaligned) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            rdata     <= 32'h0;
                        end else begin
                            state_reg <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_be    <= be_next;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack || timer_reg == TIMER_LAST) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        err       <= !mem_ack;
                        rdata     <= (mem_ack && !write_reg) ? load_data : 32'h0;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule
